// File: rtl/game_pkg.sv
// Shared definitions for the game command generator and the game state machine.
//  - GAME_* : 2-bit state encodings seen on state_in
//  - game_cmd_t : bundle of the four one-cycle command pulses
package game_pkg;

  localparam logic [1:0] GAME_RUNNING = 2'b00;
  localparam logic [1:0] GAME_PAUSED  = 2'b01;
  localparam logic [1:0] GAME_OVER    = 2'b10;

  typedef struct packed {
    logic start;
    logic resume;
    logic pause;
    logic die;
  } game_cmd_t;

  localparam game_cmd_t CMD_NONE = '{start: 1'b0, resume: 1'b0, pause: 1'b0, die: 1'b0};

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, debounce counter, press-edge detector.
// Ports:
//  clk    in   system clock
//  reset  in   synchronous active-high reset
//  btn    in   raw asynchronous button
//  press  out  registered one-cycle pulse on each rising edge of the debounced level
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            hist_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (int'(cnt_q) + 1 >= int'(DEBOUNCE_CYCLES) - 1) begin
      // The counter would reach DEBOUNCE_CYCLES-1 on this edge: accept the new level.
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      hist_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      hist_q  <= level_q;
      press_q <= level_q & ~hist_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_cmd_gen.sv
// Command producer for the game state machine.
// Debounces the start/pause buttons, tracks remaining lives from hit events and emits
// registered one-cycle start/resume/pause/die pulses decoded against state_in.
// Ports:
//  clk, reset          clock and synchronous active-high reset
//  btn_start/btn_pause raw asynchronous buttons
//  hit                 synchronous one-cycle hit event
//  state_in            current game state (game_pkg encodings, 2'b11 illegal)
//  start/resume/pause/die  one-cycle command pulses (at most one high)
//  lives               lives remaining
module game_cmd_gen
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned LIVES_W         = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               hit,
  input  logic [1:0]         state_in,
  output logic               start,
  output logic               resume,
  output logic               pause,
  output logic               die,
  output logic [LIVES_W-1:0] lives
);

  logic start_press, pause_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_start_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pause_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_pause),
    .press (pause_press)
  );

  game_cmd_t          cmd_q, cmd_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               running, paused, over, hit_ok;

  assign running = (state_in == GAME_RUNNING);
  assign paused  = (state_in == GAME_PAUSED);
  assign over    = (state_in == GAME_OVER);
  assign hit_ok  = hit & running;

  always_comb begin
    cmd_d   = CMD_NONE;
    lives_d = lives_q;

    if (start_press && over) begin
      cmd_d.start = 1'b1;
      lives_d     = LIVES_W'(LIVES);
    end

    if (hit_ok && (lives_q != '0)) begin
      lives_d   = lives_q - 1'b1;
      cmd_d.die = (lives_q == LIVES_W'(1));
    end

    // A fatal hit takes precedence over a pause press on the same edge.
    cmd_d.pause  = pause_press & running & ~cmd_d.die;
    cmd_d.resume = pause_press & paused;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= CMD_NONE;
      lives_q <= LIVES_W'(LIVES);
    end else begin
      cmd_q   <= cmd_d;
      lives_q <= lives_d;
    end
  end

  assign start  = cmd_q.start;
  assign resume = cmd_q.resume;
  assign pause  = cmd_q.pause;
  assign die    = cmd_q.die;
  assign lives  = lives_q;

endmodule

// File: tb/tb_game_cmd_gen.sv
// Directed bench for game_cmd_gen with a scoreboard of expected outputs keyed by edge number.
module tb_game_cmd_gen;

  localparam int unsigned D = 4;
  localparam int unsigned L = 3;
  localparam int unsigned W = 2;

  localparam logic [3:0] NONE   = 4'b0000;
  localparam logic [3:0] START  = 4'b1000;
  localparam logic [3:0] RESUME = 4'b0100;
  localparam logic [3:0] PAUSE  = 4'b0010;
  localparam logic [3:0] DIE    = 4'b0001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_start = 1'b0;
  logic         btn_pause = 1'b0;
  logic         hit = 1'b0;
  logic [1:0]   state_in = 2'b00;
  logic         start, resume, pause, die;
  logic [W-1:0] lives;

  game_cmd_gen #(
    .DEBOUNCE_CYCLES (D),
    .LIVES           (L),
    .LIVES_W         (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .hit       (hit),
    .state_in  (state_in),
    .start     (start),
    .resume    (resume),
    .pause     (pause),
    .die       (die),
    .lives     (lives)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a negedge it names the edge just taken.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  cmd;
    logic [W-1:0] lv;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   idle_chk = 1'b0;

  // Sorted insert so steps may push entries in any order.
  task automatic exp_at(input int unsigned e, input logic [3:0] cmd, input int unsigned lv,
                        input string tag);
    exp_t x;
    int   pos;
    x.edge_n = e;
    x.cmd    = cmd;
    x.lv     = W'(lv);
    x.tag    = tag;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].edge_n > e) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, x);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard checker: full compare on scheduled edges, no-pulse check elsewhere.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] got;
    got = {start, resume, pause, die};
    while (sb.size() > 0 && sb[0].edge_n < cyc) begin
      e = sb.pop_front();
      total++;
      assert (e.edge_n >= cyc) else begin
        bad++;
        $error("FAIL %s: edge %0d skipped, observed none, expected check", e.tag, e.edge_n);
      end
    end
    if (sb.size() > 0 && sb[0].edge_n == cyc) begin
      e = sb.pop_front();
      total++;
      assert (got === e.cmd && lives === e.lv) else begin
        bad++;
        $error("FAIL %s: edge %0d observed cmd=%b lives=%0d expected cmd=%b lives=%0d",
               e.tag, cyc, got, lives, e.cmd, e.lv);
      end
    end else if (idle_chk) begin
      total++;
      assert (got === NONE) else begin
        bad++;
        $error("FAIL idle: edge %0d observed cmd=%b expected cmd=%b", cyc, got, NONE);
      end
    end
  end

  int unsigned c;

  initial begin
    // Reset state
    step(2);
    c = cyc;
    exp_at(c + 1, NONE, L, "reset_state");
    step(1);
    reset = 1'b0;
    idle_chk = 1'b1;

    // 1. Clean pause press while running: pulse D+2 edges after first sample
    c = cyc;
    btn_pause = 1'b1;
    exp_at(c + 6, NONE, L, "t1_pre");
    exp_at(c + 7, PAUSE, L, "t1_pause");
    exp_at(c + 8, NONE, L, "t1_post");
    step(12);
    btn_pause = 1'b0;
    step(10);

    // 2a. Glitch shorter than the debounce window: no pulse
    c = cyc;
    btn_pause = 1'b1;
    step(2);
    btn_pause = 1'b0;
    exp_at(c + 9, NONE, L, "t2_glitch");
    step(10);

    // 2b. Bounce 1-0-1 while paused: counter restarts, resume after last change
    state_in = 2'b01;
    c = cyc;
    btn_pause = 1'b1;
    step(1);
    btn_pause = 1'b0;
    step(1);
    btn_pause = 1'b1;
    exp_at(c + 8, NONE, L, "t2_bounce_pre");
    exp_at(c + 9, RESUME, L, "t2_bounce_resume");
    step(12);
    btn_pause = 1'b0;
    step(10);
    state_in = 2'b00;

    // 3. Three hits while running, then saturation and ignored hits in over
    c = cyc;
    hit = 1'b1;
    exp_at(c + 1, NONE, 2, "t3_hit1");
    exp_at(c + 2, NONE, 1, "t3_hit2");
    exp_at(c + 3, DIE, 0, "t3_hit3_die");
    step(3);
    hit = 1'b0;
    exp_at(c + 4, NONE, 0, "t3_after_die");
    step(2);
    c = cyc;
    hit = 1'b1;
    exp_at(c + 1, NONE, 0, "t3_sat_running");
    step(1);
    state_in = 2'b10;
    exp_at(c + 2, NONE, 0, "t3_over_hit1");
    exp_at(c + 3, NONE, 0, "t3_over_hit2");
    step(2);
    hit = 1'b0;
    step(2);

    // 4. Start press in over reloads lives; start press while running ignored
    c = cyc;
    btn_start = 1'b1;
    exp_at(c + 6, NONE, 0, "t4_pre");
    exp_at(c + 7, START, L, "t4_start");
    step(12);
    btn_start = 1'b0;
    step(10);
    state_in = 2'b00;
    c = cyc;
    btn_start = 1'b1;
    exp_at(c + 7, NONE, L, "t4_ignored");
    step(12);
    btn_start = 1'b0;
    step(10);

    // 5a. Pause press with a non-fatal hit on the press edge
    c = cyc;
    btn_pause = 1'b1;
    step(6);
    hit = 1'b1;
    exp_at(c + 7, PAUSE, 2, "t5_pause_hit");
    step(1);
    hit = 1'b0;
    step(10);
    btn_pause = 1'b0;
    step(10);
    c = cyc;
    hit = 1'b1;
    exp_at(c + 1, NONE, 1, "t5_to_one");
    step(1);
    hit = 1'b0;
    step(2);

    // 5b. Pause press with a fatal hit: die wins
    c = cyc;
    btn_pause = 1'b1;
    step(6);
    hit = 1'b1;
    exp_at(c + 7, DIE, 0, "t5_die_wins");
    exp_at(c + 8, NONE, 0, "t5_after");
    step(1);
    hit = 1'b0;
    step(10);
    btn_pause = 1'b0;
    step(10);

    // 6a. Reset with the debounce counter at 2, button released: no pulse
    c = cyc;
    btn_pause = 1'b1;
    step(4);
    reset = 1'b1;
    exp_at(c + 5, NONE, L, "t6_reset");
    step(1);
    reset = 1'b0;
    btn_pause = 1'b0;
    exp_at(c + 12, NONE, L, "t6_released");
    step(15);

    // 6b. Same, but held across reset: one press D+2 edges after first post-reset sample
    c = cyc;
    btn_pause = 1'b1;
    step(4);
    reset = 1'b1;
    exp_at(c + 5, NONE, L, "t6b_reset");
    step(1);
    reset = 1'b0;
    exp_at(c + 11, NONE, L, "t6b_pre");
    exp_at(c + 12, PAUSE, L, "t6b_pause");
    exp_at(c + 13, NONE, L, "t6b_post");
    step(15);
    btn_pause = 1'b0;
    step(10);

    idle_chk = 1'b0;
    step(1);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain: observed %0d pending entries, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
